// File: rtl/satswarmv2_pkg.sv
// Types shared between the clause export and import sides of the swarm.
// The packet layout is fixed here so both sides agree on the wire format.
package satswarmv2_pkg;

    localparam int NUM_CORES_DEF = 4;
    localparam int CORE_ID_W     = $clog2(NUM_CORES_DEF);
    localparam int LIT_W         = 16;

    typedef struct packed {
        logic [CORE_ID_W-1:0] src_id;
        logic [LIT_W-1:0]     lit0;
        logic [LIT_W-1:0]     lit1;
    } shared_packet_t;

    // Canonical order lit0 <= lit1 so {a,b} and {b,a} compare equal.
    function automatic shared_packet_t normalize_pair(input shared_packet_t p);
        shared_packet_t r;
        r = p;
        if (p.lit0 > p.lit1) begin
            r.lit0 = p.lit1;
            r.lit1 = p.lit0;
        end
        return r;
    endfunction

endpackage

// File: rtl/import_fifo.sv
// First-word-fall-through FIFO with a same-cycle pop-before-push rule:
// a full FIFO still accepts a push in the cycle its head is popped.
module import_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             push_ok
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    assign push_ok = !full || do_pop;
    assign do_push = push && push_ok;
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/shared_clause_importer.sv
// Per-core consumer of the shared clause broadcast: normalizes packets, drops
// self-origin and recently seen clauses, and queues the rest for the core.
module shared_clause_importer
    import satswarmv2_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int CORE_ID    = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int HIST_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bcast_valid,
    input  shared_packet_t   bcast_payload,
    input  logic             flush,
    output logic             imp_valid,
    output shared_packet_t   imp_payload,
    input  logic             imp_ready,
    output logic [CNT_W-1:0] cnt_imported,
    output logic [CNT_W-1:0] cnt_self,
    output logic [CNT_W-1:0] cnt_dup,
    output logic [CNT_W-1:0] cnt_ovf
);

    localparam int HP_W  = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int PKT_W = $bits(shared_packet_t);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    shared_packet_t       s1_pkt;
    logic                 s1_valid;
    logic                 s1_self;
    logic [2*LIT_W-1:0]   hist_lits [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] hist_valid;
    logic [HP_W-1:0]      hist_ptr;
    logic                 hit;
    logic                 s2_act;
    logic                 drop_self;
    logic                 drop_dup;
    logic                 want_push;
    logic                 push_ok;
    logic                 do_push;
    logic [PKT_W-1:0]     fifo_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_self  <= 1'b0;
            s1_pkt   <= '0;
        end else begin
            s1_valid <= bcast_valid && !flush;
            s1_self  <= (CORE_ID < NUM_CORES) &&
                        (bcast_payload.src_id == CORE_ID_W'(CORE_ID));
            s1_pkt   <= normalize_pair(bcast_payload);
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (hist_valid[i] && hist_lits[i] == {s1_pkt.lit0, s1_pkt.lit1}) hit = 1'b1;
        end
    end

    // A flush in the same cycle kills the S1 packet without accounting for it.
    assign s2_act    = s1_valid && !flush;
    assign drop_self = s2_act && s1_self;
    assign drop_dup  = s2_act && !s1_self && hit;
    assign want_push = s2_act && !s1_self && !hit;
    assign do_push   = want_push && push_ok;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            hist_valid <= '0;
            hist_ptr   <= '0;
        end else if (do_push) begin
            hist_lits[hist_ptr]  <= {s1_pkt.lit0, s1_pkt.lit1};
            hist_valid[hist_ptr] <= 1'b1;
            hist_ptr <= (hist_ptr == HP_W'(HIST_DEPTH-1)) ? '0 : hist_ptr + HP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_imported <= '0;
            cnt_self     <= '0;
            cnt_dup      <= '0;
            cnt_ovf      <= '0;
        end else begin
            if (do_push)               cnt_imported <= sat_inc(cnt_imported);
            if (drop_self)             cnt_self     <= sat_inc(cnt_self);
            if (drop_dup)              cnt_dup      <= sat_inc(cnt_dup);
            if (want_push && !push_ok) cnt_ovf      <= sat_inc(cnt_ovf);
        end
    end

    import_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (do_push),
        .push_data (s1_pkt),
        .pop       (imp_ready),
        .head      (fifo_head),
        .valid     (imp_valid),
        .push_ok   (push_ok)
    );

    assign imp_payload = shared_packet_t'(fifo_head);

endmodule

// File: tb/tb_shared_clause_importer.sv
// Directed bench for shared_clause_importer at CORE_ID=0, FIFO_DEPTH=16, HIST_DEPTH=8.
module tb_shared_clause_importer;
    import satswarmv2_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           bcast_valid;
    shared_packet_t bcast_payload;
    logic           flush;
    logic           imp_valid;
    shared_packet_t imp_payload;
    logic           imp_ready;
    logic [15:0]    cnt_imported, cnt_self, cnt_dup, cnt_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    shared_clause_importer #(
        .NUM_CORES(4), .CORE_ID(0), .FIFO_DEPTH(16), .HIST_DEPTH(8), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .bcast_valid(bcast_valid), .bcast_payload(bcast_payload),
        .flush(flush), .imp_valid(imp_valid), .imp_payload(imp_payload),
        .imp_ready(imp_ready), .cnt_imported(cnt_imported), .cnt_self(cnt_self),
        .cnt_dup(cnt_dup), .cnt_ovf(cnt_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int src, input int l0, input int l1);
        bcast_valid          = 1'b1;
        bcast_payload.src_id = CORE_ID_W'(src);
        bcast_payload.lit0   = LIT_W'(l0);
        bcast_payload.lit1   = LIT_W'(l1);
        step();
        bcast_valid   = 1'b0;
        bcast_payload = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; bcast_valid = 1'b0; bcast_payload = '0; imp_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        n_cmp++; if (imp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", imp_valid); end
        n_cmp++; if (imp_payload !== '0) begin n_bad++; $display("FAIL reset_payload got %h want 0", imp_payload); end
        n_cmp++; if ({cnt_imported, cnt_self, cnt_dup, cnt_ovf} !== 64'd0) begin
            n_bad++; $display("FAIL reset_counters got %0d %0d %0d %0d want 0 0 0 0", cnt_imported, cnt_self, cnt_dup, cnt_ovf);
        end
    endtask

    task automatic test_single();
        imp_ready = 1'b0;
        send(1, 9, 4);
        n_cmp++; if (imp_valid !== 1'b0) begin n_bad++; $display("FAIL single_t1_valid got %b want 0", imp_valid); end
        step();
        n_cmp++; if (imp_valid !== 1'b1) begin n_bad++; $display("FAIL single_t2_valid got %b want 1", imp_valid); end
        n_cmp++; if (imp_payload.lit0 !== 16'd4 || imp_payload.lit1 !== 16'd9 || imp_payload.src_id !== 2'd1) begin
            n_bad++; $display("FAIL single_payload got src=%0d %0d/%0d want src=1 4/9", imp_payload.src_id, imp_payload.lit0, imp_payload.lit1);
        end
        n_cmp++; if (cnt_imported !== 16'd1) begin n_bad++; $display("FAIL single_cnt got %0d want 1", cnt_imported); end
        step();
        n_cmp++; if (imp_payload.lit0 !== 16'd4) begin n_bad++; $display("FAIL single_hold got %0d want 4", imp_payload.lit0); end
        imp_ready = 1'b1;
        step();
        imp_ready = 1'b0;
        n_cmp++; if (imp_valid !== 1'b0) begin n_bad++; $display("FAIL single_pop_valid got %b want 0", imp_valid); end
    endtask

    task automatic test_self();
        int seen;
        seen = 0;
        send(0, 5, 6);
        for (int i = 0; i < 4; i++) begin
            if (imp_valid) seen++;
            step();
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL self_valid got %0d cycles want 0", seen); end
        n_cmp++; if (cnt_self !== 16'd1) begin n_bad++; $display("FAIL self_cnt got %0d want 1", cnt_self); end
        n_cmp++; if (cnt_imported !== 16'd1) begin n_bad++; $display("FAIL self_imp got %0d want 1", cnt_imported); end
    endtask

    task automatic test_dup();
        imp_ready = 1'b1;
        send(2, 3, 7);
        send(3, 7, 3);
        repeat (20) step();
        send(1, 3, 7);
        step(); step();
        n_cmp++; if (cnt_imported !== 16'd2) begin n_bad++; $display("FAIL dup_imp got %0d want 2", cnt_imported); end
        n_cmp++; if (cnt_dup !== 16'd2) begin n_bad++; $display("FAIL dup_cnt got %0d want 2", cnt_dup); end
        for (int i = 0; i < 8; i++) send(1, 100 + i, 200 + i);
        send(2, 7, 3);
        step(); step();
        n_cmp++; if (cnt_imported !== 16'd11) begin n_bad++; $display("FAIL dup_evict_imp got %0d want 11", cnt_imported); end
        n_cmp++; if (cnt_dup !== 16'd2) begin n_bad++; $display("FAIL dup_evict_dup got %0d want 2", cnt_dup); end
        step();
        imp_ready = 1'b0;
        n_cmp++; if (imp_valid !== 1'b0) begin n_bad++; $display("FAIL dup_drained got %b want 0", imp_valid); end
    endtask

    task automatic test_overflow();
        imp_ready = 1'b0;
        for (int i = 0; i < 20; i++) send(1, 300 + i, 400 + i);
        step(); step();
        n_cmp++; if (cnt_imported !== 16'd27) begin n_bad++; $display("FAIL ovf_imp got %0d want 27", cnt_imported); end
        n_cmp++; if (cnt_ovf !== 16'd4) begin n_bad++; $display("FAIL ovf_cnt got %0d want 4", cnt_ovf); end
        imp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (imp_valid !== 1'b1 || imp_payload.lit0 !== 16'(300 + i) || imp_payload.lit1 !== 16'(400 + i)) begin
                n_bad++; $display("FAIL ovf_drain[%0d] got v=%b %0d/%0d want v=1 %0d/%0d", i, imp_valid, imp_payload.lit0, imp_payload.lit1, 300 + i, 400 + i);
            end
            step();
        end
        imp_ready = 1'b0;
        n_cmp++; if (imp_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty got %b want 0", imp_valid); end
    endtask

    task automatic test_full_pop();
        imp_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(2, 500 + i, 600 + i);
        step(); step();
        n_cmp++; if (cnt_imported !== 16'd43) begin n_bad++; $display("FAIL full_fill got %0d want 43", cnt_imported); end
        send(1, 800, 700);
        imp_ready = 1'b1;
        step();
        imp_ready = 1'b0;
        n_cmp++; if (cnt_imported !== 16'd44) begin n_bad++; $display("FAIL full_pop_imp got %0d want 44", cnt_imported); end
        n_cmp++; if (cnt_ovf !== 16'd4) begin n_bad++; $display("FAIL full_pop_ovf got %0d want 4", cnt_ovf); end
        send(1, 900, 901);
        step();
        n_cmp++; if (cnt_ovf !== 16'd5) begin n_bad++; $display("FAIL full_still16 got %0d want 5", cnt_ovf); end
        imp_ready = 1'b1;
        for (int i = 1; i < 17; i++) begin
            n_cmp++;
            if (i < 16) begin
                if (imp_valid !== 1'b1 || imp_payload.lit0 !== 16'(500 + i)) begin
                    n_bad++; $display("FAIL full_drain[%0d] got v=%b %0d want v=1 %0d", i, imp_valid, imp_payload.lit0, 500 + i);
                end
            end else if (imp_valid !== 1'b1 || imp_payload.lit0 !== 16'd700 || imp_payload.lit1 !== 16'd800) begin
                n_bad++; $display("FAIL full_drain_last got v=%b %0d/%0d want v=1 700/800", imp_valid, imp_payload.lit0, imp_payload.lit1);
            end
            step();
        end
        imp_ready = 1'b0;
        n_cmp++; if (imp_valid !== 1'b0) begin n_bad++; $display("FAIL full_empty got %b want 0", imp_valid); end
    endtask

    task automatic test_flush();
        imp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(1, 1000 + i, 1100 + i);
        send(1, 1200, 1300);
        flush = 1'b1;
        send(1, 1400, 1500);
        flush = 1'b0;
        n_cmp++; if (imp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b want 0", imp_valid); end
        step(); step();
        n_cmp++; if (imp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_inflight got %b want 0", imp_valid); end
        n_cmp++; if (cnt_imported !== 16'd49 || cnt_self !== 16'd1 || cnt_dup !== 16'd2 || cnt_ovf !== 16'd5) begin
            n_bad++; $display("FAIL flush_counters got %0d %0d %0d %0d want 49 1 2 5", cnt_imported, cnt_self, cnt_dup, cnt_ovf);
        end
        send(3, 1100, 1000);
        step();
        n_cmp++; if (imp_valid !== 1'b1 || imp_payload.lit0 !== 16'd1000 || imp_payload.lit1 !== 16'd1100) begin
            n_bad++; $display("FAIL flush_reimport got v=%b %0d/%0d want v=1 1000/1100", imp_valid, imp_payload.lit0, imp_payload.lit1);
        end
        n_cmp++; if (cnt_imported !== 16'd50) begin n_bad++; $display("FAIL flush_reimport_cnt got %0d want 50", cnt_imported); end
    endtask

    task automatic test_reset_midstream();
        send(2, 2000, 2001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if ({cnt_imported, cnt_self, cnt_dup, cnt_ovf} !== 64'd0) begin
            n_bad++; $display("FAIL rst_counters got %0d %0d %0d %0d want 0 0 0 0", cnt_imported, cnt_self, cnt_dup, cnt_ovf);
        end
        step(); step();
        n_cmp++; if (imp_valid !== 1'b0 || cnt_imported !== 16'd0) begin
            n_bad++; $display("FAIL rst_inflight got v=%b imp=%0d want v=0 imp=0", imp_valid, cnt_imported);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_self();
        test_dup();
        test_overflow();
        test_full_pop();
        test_flush();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
